// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Groups the pipeline hazard-detection inputs and the pipeline control
// outputs of pipe_hazard_ctrl into one bundle.
//   slave  : the hazard controller (samples hazard inputs, drives controls)
//   master : the pipeline / stimulus side (drives hazard inputs)
// Signals:
//   ID_Areg, ID_Breg, ID_usesA, ID_usesB : decode-stage source operands
//   EX_targetReg, EX_memRead             : execute-stage destination / load flag
//   jumpEnable                           : jump resolved taken this cycle
//   memReq, memReady                     : memory-stage access handshake.
//                                          memReq=1 means an access is in
//                                          progress; it completes in the cycle
//                                          memReady=1. memReady may be high
//                                          on the same cycle memReq rises.
//   pcStall .. EX_MEMstall               : per-stage hold/flush/bubble controls
//   memTimeout, state_o, stallCount      : status and debug
interface pipe_hazard_ctrl_if;
  logic [2:0] ID_Areg;
  logic [2:0] ID_Breg;
  logic       ID_usesA;
  logic       ID_usesB;
  logic [2:0] EX_targetReg;
  logic       EX_memRead;
  logic       jumpEnable;
  logic       memReq;
  logic       memReady;
  logic       pcStall;
  logic       IF_IDstall;
  logic       IF_IDflush;
  logic       ID_EXbubble;
  logic       ID_EXstall;
  logic       jumpClear;
  logic       EX_MEMstall;
  logic       memTimeout;
  logic [1:0] state_o;
  logic [7:0] stallCount;

  modport slave (
    input  ID_Areg, ID_Breg, ID_usesA, ID_usesB, EX_targetReg, EX_memRead,
    input  jumpEnable, memReq, memReady,
    output pcStall, IF_IDstall, IF_IDflush, ID_EXbubble, ID_EXstall,
    output jumpClear, EX_MEMstall, memTimeout, state_o, stallCount
  );

  modport master (
    output ID_Areg, ID_Breg, ID_usesA, ID_usesB, EX_targetReg, EX_memRead,
    output jumpEnable, memReq, memReady,
    input  pcStall, IF_IDstall, IF_IDflush, ID_EXbubble, ID_EXstall,
    input  jumpClear, EX_MEMstall, memTimeout, state_o, stallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard controller: resolves taken jumps (2-cycle flush), memory
// waits (full pipeline stall until memReady) and load-use hazards (one bubble).
// Ports:
//   clk : system clock, all state on posedge
//   rst : synchronous active-high reset; forces every control output low
//   bus : pipe_hazard_ctrl_if.slave (hazard inputs, control outputs, status)
// Control outputs are combinational from the current state and inputs so the
// pipeline reacts in the same cycle a hazard is visible.
module pipe_hazard_ctrl (
  input  logic                      clk,
  input  logic                      rst,
  pipe_hazard_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_wait_cnt;
  logic       r_mem_timeout;
  logic [7:0] r_stall_cnt;

  logic w_load_use;
  logic w_mem_busy;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_idex_stall;
  logic w_jump_clear;
  logic w_exmem_stall;
  logic w_wait_load;
  logic w_wait_inc;

  assign w_load_use = bus.EX_memRead &
                      ((bus.ID_usesA & (bus.ID_Areg == bus.EX_targetReg)) |
                       (bus.ID_usesB & (bus.ID_Breg == bus.EX_targetReg)));
  assign w_mem_busy = bus.memReq & ~bus.memReady;

  always_comb begin
    w_state_next  = ST_RUN;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_idex_stall  = 1'b0;
    w_jump_clear  = 1'b0;
    w_exmem_stall = 1'b0;
    w_wait_load   = 1'b0;
    w_wait_inc    = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Jump beats memory wait beats load-use; only one action per cycle.
        if (bus.jumpEnable) begin
          w_jump_clear = 1'b1;
          w_ifid_flush = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (w_mem_busy) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_wait_load   = 1'b1;
          w_state_next  = ST_MEMWAIT;
        end else if (w_load_use) begin
          // The load leaves execute next cycle, so one bubble suffices.
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Second flush cycle of a taken jump; all other hazards ignored.
        w_jump_clear = 1'b1;
        w_ifid_flush = 1'b1;
      end
      ST_MEMWAIT: begin
        if (!bus.memReady) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_wait_inc    = 1'b1;
          w_state_next  = ST_MEMWAIT;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
    if (rst) begin
      w_state_next  = ST_RUN;
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_idex_stall  = 1'b0;
      w_jump_clear  = 1'b0;
      w_exmem_stall = 1'b0;
      w_wait_load   = 1'b0;
      w_wait_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 4'd0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_load) begin
        r_wait_cnt <= 4'd1;
      end else if (w_wait_inc && (r_wait_cnt != 4'd15)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      // Sticky: set on the edge the wait counter reaches its ceiling.
      if (w_wait_inc && (r_wait_cnt == 4'd14)) begin
        r_mem_timeout <= 1'b1;
      end
      if (w_pc_stall && (r_stall_cnt != 8'd255)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
    end
  end

  assign bus.pcStall     = w_pc_stall;
  assign bus.IF_IDstall  = w_ifid_stall;
  assign bus.IF_IDflush  = w_ifid_flush;
  assign bus.ID_EXbubble = w_idex_bubble;
  assign bus.ID_EXstall  = w_idex_stall;
  assign bus.jumpClear   = w_jump_clear;
  assign bus.EX_MEMstall = w_exmem_stall;
  assign bus.memTimeout  = r_mem_timeout;
  assign bus.state_o     = r_state;
  assign bus.stallCount  = r_stall_cnt;

endmodule
